// File: rtl/btn_pkg.sv
// Shared definitions for the pushbutton front end: event source encoding,
// index width helper and default timing constants.
package btn_pkg;

    typedef enum logic {
        SRC_PRESS = 1'b0,
        SRC_REL   = 1'b1
    } evt_src_e;

    localparam int unsigned DEF_TICK_DIV     = 100000;
    localparam int unsigned DEF_STABLE_TICKS = 10;

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_filter.sv
// One-bit pushbutton conditioner: 2-flop synchroniser followed by a
// tick-driven stability counter; rise/fall pulse in the cycle the level flips.
module btn_filter
    import btn_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = idx_width(STABLE_TICKS);

    logic          r_sync0;
    logic          r_sync1;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          w_diff;
    logic          w_done;

    assign w_diff = r_sync1 ^ r_level;
    assign w_done = tick & w_diff & (r_cnt == CW'(STABLE_TICKS - 1));
    assign rise   = w_done & r_sync1;
    assign fall   = w_done & ~r_sync1;
    assign level  = r_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync0 <= raw;
            r_sync1 <= r_sync0;
            if (tick) begin
                // Any agreeing tick restarts the run of differing ticks.
                if (!w_diff || w_done) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
                if (w_done) begin
                    r_level <= ~r_level;
                end
            end
        end
    end

endmodule

// File: rtl/button_ctrl.sv
// Pushbutton controller: shared prescaler, N debounce filters, per-button
// pending/overflow tracking and a round-robin event output with valid/ready.
// Define RELEASE_EVT_EN to also report release events.
module button_ctrl
    import btn_pkg::*;
#(
    parameter int unsigned N            = 4,
    parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
    parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N-1:0]            pbi,
    output logic [N-1:0]            pbo,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [idx_width(N)-1:0] evt_idx,
    output logic                    evt_rel,
    output logic [N-1:0]            ovf,
    input  logic                    ovf_clr
);

    localparam int unsigned IW = idx_width(N);
    localparam int unsigned PW = idx_width(TICK_DIV);
`ifdef RELEASE_EVT_EN
    localparam int unsigned NS = 2 * N;
`else
    localparam int unsigned NS = N;
`endif
    localparam int unsigned SW = idx_width(NS);

    logic [PW-1:0] r_pre;
    logic [NS-1:0] r_pend;
    logic [N-1:0]  r_ovf;
    logic [SW-1:0] r_rr;
    logic          r_evt_valid;
    logic [IW-1:0] r_evt_idx;

    logic          w_tick;
    logic [N-1:0]  w_rise;
    logic [N-1:0]  w_fall;
    logic [NS-1:0] w_set;
    logic [NS-1:0] w_clr;
    logic [N-1:0]  w_ovf_set;
    logic [NS-1:0] w_rot;
    logic          w_found;
    logic [SW-1:0] w_off;
    logic [SW:0]   w_sum;
    logic [SW-1:0] w_win;
    logic [SW-1:0] w_rr_nxt;
    logic          w_load;

    assign w_tick = (r_pre == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PW'(1);
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_btn
        btn_filter #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_filter (
            .clk  (clk),
            .rst_n(rst_n),
            .tick (w_tick),
            .raw  (pbi[i]),
            .level(pbo[i]),
            .rise (w_rise[i]),
            .fall (w_fall[i])
        );
    end

`ifdef RELEASE_EVT_EN
    // Sources interleave as press0, rel0, press1, rel1, ...
    for (genvar i = 0; i < N; i++) begin : g_src
        localparam int unsigned PI = 2 * i + int'(SRC_PRESS);
        localparam int unsigned RI = 2 * i + int'(SRC_REL);
        assign w_set[PI]    = w_rise[i];
        assign w_set[RI]    = w_fall[i];
        assign w_ovf_set[i] = (w_rise[i] & r_pend[PI]) | (w_fall[i] & r_pend[RI]);
    end
`else
    logic w_unused_fall;
    assign w_unused_fall = ^w_fall;
    assign w_set         = w_rise;
    assign w_ovf_set     = w_rise & r_pend;
`endif

    // Round-robin pick: rotate pending so the RR pointer sits at bit 0.
    assign w_rot = NS'({r_pend, r_pend} >> r_rr);

    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int k = 0; k < int'(NS); k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_off   = SW'(k);
            end
        end
    end

    assign w_sum    = {1'b0, r_rr} + {1'b0, w_off};
    assign w_win    = (w_sum >= (SW+1)'(NS)) ? SW'(w_sum - (SW+1)'(NS)) : SW'(w_sum);
    assign w_rr_nxt = (w_win == SW'(NS - 1)) ? '0 : w_win + SW'(1);
    assign w_load   = w_found & (~r_evt_valid | evt_ready);
    assign w_clr    = w_load ? (NS'(1) << w_win) : '0;

    // A new set in the same cycle as the grant-clear keeps the bit pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
            r_ovf  <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_set;
            r_ovf  <= (ovf_clr ? '0 : r_ovf) | w_ovf_set;
        end
    end

`ifdef RELEASE_EVT_EN
    logic r_evt_rel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_evt_rel <= 1'b0;
        end else if (w_load) begin
            r_evt_rel <= (evt_src_e'(w_win[0]) == SRC_REL);
        end
    end

    assign evt_rel = r_evt_rel;
`else
    assign evt_rel = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_evt_valid <= 1'b0;
            r_evt_idx   <= '0;
            r_rr        <= '0;
        end else if (w_load) begin
            r_evt_valid <= 1'b1;
`ifdef RELEASE_EVT_EN
            r_evt_idx   <= IW'(w_win >> 1);
`else
            r_evt_idx   <= IW'(w_win);
`endif
            r_rr        <= w_rr_nxt;
        end else if (evt_ready) begin
            r_evt_valid <= 1'b0;
        end
    end

    assign evt_valid = r_evt_valid;
    assign evt_idx   = r_evt_idx;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_button_ctrl.sv
// Scoreboard bench for button_ctrl: a behavioural model predicts levels,
// overflow flags and the event stream; accepted events are matched from a queue.
module tb_button_ctrl;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int ST = 3;
`ifdef RELEASE_EVT_EN
    localparam int NS  = 2 * N;
    localparam bit REL = 1'b1;
`else
    localparam int NS  = N;
    localparam bit REL = 1'b0;
`endif

    typedef struct {
        int idx;
        bit rel;
    } ev_t;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic [N-1:0] pbi       = '0;
    logic         evt_ready = 1'b0;
    logic         ovf_clr   = 1'b0;
    logic [N-1:0] pbo;
    logic [N-1:0] ovf;
    logic         evt_valid;
    logic [1:0]   evt_idx;
    logic         evt_rel;

    int n_checks = 0;
    int n_errors = 0;
    int cnt_press[N];
    int cnt_rel[N];

    // Reference model state
    int           m_cyc;
    logic [N-1:0] m_h1, m_h2, m_lvl, m_ovf;
    int           m_run[N];
    bit           m_pend[NS];
    int           m_rr;
    bit           m_valid;
    int           m_idx;
    bit           m_rel;
    ev_t          exp_q[$];

    always #5 clk = ~clk;

    button_ctrl #(
        .N(N), .TICK_DIV(TD), .STABLE_TICKS(ST)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pbi      (pbi),
        .pbo      (pbo),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_idx  (evt_idx),
        .evt_rel  (evt_rel),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int src(input int i, input int r);
        return REL ? 2 * i + r : i;
    endfunction

    task automatic model_reset();
        m_cyc = 0; m_h1 = '0; m_h2 = '0; m_lvl = '0; m_ovf = '0;
        m_rr = 0; m_valid = 1'b0; m_idx = 0; m_rel = 1'b0;
        for (int i = 0; i < N; i++) m_run[i] = 0;
        for (int j = 0; j < NS; j++) m_pend[j] = 1'b0;
        exp_q.delete();
    endtask

    // Advance the model by one clock using the inputs the DUT is about to sample.
    task automatic model_step();
        bit           tick, any, got;
        logic [N-1:0] fin, onew;
        bit           rise[N], fall[N];
        int           j, w;
        ev_t          e;
        tick = (m_cyc % TD) == TD - 1;
        m_cyc++;
        fin  = m_h2; m_h2 = m_h1; m_h1 = pbi;
        onew = '0;
        for (int i = 0; i < N; i++) begin
            rise[i] = 1'b0; fall[i] = 1'b0;
            if (tick) begin
                if (fin[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == ST) begin
                        m_lvl[i] = fin[i];
                        m_run[i] = 0;
                        rise[i]  = fin[i];
                        fall[i]  = !fin[i];
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            if (rise[i] && m_pend[src(i, 0)]) onew[i] = 1'b1;
            if (REL && fall[i] && m_pend[src(i, 1)]) onew[i] = 1'b1;
        end
        any = 1'b0;
        for (int k = 0; k < NS; k++) any |= m_pend[k];
        if (any && (!m_valid || evt_ready)) begin
            got = 1'b0; w = 0;
            for (int k = 0; k < NS; k++) begin
                j = (m_rr + k) % NS;
                if (!got && m_pend[j]) begin got = 1'b1; w = j; end
            end
            m_pend[w] = 1'b0;
            m_valid   = 1'b1;
            m_idx     = REL ? w / 2 : w;
            m_rel     = REL ? bit'(w % 2) : 1'b0;
            m_rr      = (w + 1) % NS;
            e.idx = m_idx; e.rel = m_rel;
            exp_q.push_back(e);
        end else if (m_valid && evt_ready) begin
            m_valid = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (rise[i]) m_pend[src(i, 0)] = 1'b1;
            if (REL && fall[i]) m_pend[src(i, 1)] = 1'b1;
        end
        m_ovf = (ovf_clr ? '0 : m_ovf) | onew;
    endtask

    // Monitor: compare DUT against the model, pop accepted events, then advance.
    initial begin : monitor
        ev_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            check("pbo", 32'(pbo), 32'(m_lvl));
            check("ovf", 32'(ovf), 32'(m_ovf));
            check("evt_valid", 32'(evt_valid), 32'(m_valid));
            if (m_valid) check("evt_idx", 32'(evt_idx), m_idx);
            if (m_valid || !REL) check("evt_rel", 32'(evt_rel), 32'(m_rel));
            if (rst_n && evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_event", 32'(evt_idx), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_idx", 32'(evt_idx), e.idx);
                    check("sb_rel", 32'(evt_rel), 32'(e.rel));
                end
                if (evt_rel) cnt_rel[evt_idx]++;
                else         cnt_press[evt_idx]++;
            end
            if (rst_n) model_step();
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int b;
        for (int i = 0; i < N; i++) begin cnt_press[i] = 0; cnt_rel[i] = 0; end

        // Reset with all buttons held, then release reset.
        pbi = 4'hF; rst_n = 1'b0; evt_ready = 1'b0;
        cyc(3);
        check("rst_pbo", 32'(pbo), 32'h0);
        check("rst_valid", 32'(evt_valid), 32'h0);
        rst_n = 1'b1;
        cyc(18);
        check("t1_pbo_all", 32'(pbo), 32'hF);
        evt_ready = 1'b1;
        cyc(10);
        pbi = '0;
        cyc(24);

        // Single clean press of button 2.
        b = cnt_press[2];
        pbi[2] = 1'b1;
        cyc(30);
        check("t2_pbo2", 32'(pbo[2]), 32'h1);
        check("t2_one_press", 32'(cnt_press[2] - b), 32'h1);

        // Bouncing button 0 must never be accepted.
        b = cnt_press[0];
        repeat (12) begin pbi[0] = ~pbi[0]; cyc(5); end
        pbi[0] = 1'b0;
        cyc(20);
        check("t3_pbo0", 32'(pbo[0]), 32'h0);
        check("t3_no_event", 32'(cnt_press[0] - b), 32'h0);

        // Simultaneous presses from a fresh reset, drained in RR order.
        pbi = '0;
        cyc(24);
        rst_n = 1'b0; cyc(2); rst_n = 1'b1; cyc(4);
        evt_ready = 1'b0;
        pbi = 4'b1011;
        cyc(25);
        check("t4_valid_held", 32'(evt_valid), 32'h1);
        check("t4_idx0_held", 32'(evt_idx), 32'h0);
        evt_ready = 1'b1;
        cyc(1);
        check("t4_idx1", 32'(evt_idx), 32'h1);
        cyc(1);
        check("t4_idx3", 32'(evt_idx), 32'h3);
        cyc(1);
        check("t4_drained", 32'(evt_valid), 32'h0);

        // Coalesced presses on button 1 behind a stalled button-0 event.
        pbi = '0;
        cyc(24);
        evt_ready = 1'b0;
        b = cnt_press[1];
        pbi[0] = 1'b1; cyc(20);
        pbi[1] = 1'b1; cyc(20);
        pbi[1] = 1'b0; cyc(20);
        pbi[1] = 1'b1; cyc(20);
        check("t5_ovf1", 32'(ovf), 32'h2);
        ovf_clr = 1'b1; cyc(1); ovf_clr = 1'b0;
        check("t5_ovf_clr", 32'(ovf), 32'h0);
        evt_ready = 1'b1;
        cyc(8);
        check("t5_one_press1", 32'(cnt_press[1] - b), 32'h1);

        // Press then release button 3.
        pbi = '0;
        cyc(24);
        b = cnt_rel[3];
        pbi[3] = 1'b1; cyc(20);
        pbi[3] = 1'b0; cyc(20);
        check("t6_release_evt", 32'(cnt_rel[3] - b), REL ? 32'h1 : 32'h0);

        // Randomised traffic with a mid-run reset.
        for (int c = 0; c < 3000; c++) begin
            evt_ready = ($urandom % 4) != 0;
            ovf_clr   = ($urandom % 64) == 0;
            for (int i = 0; i < N; i++)
                if (($urandom % 12) == 0) pbi[i] = ~pbi[i];
            if (c == 1500) rst_n = 1'b0;
            if (c == 1503) rst_n = 1'b1;
            cyc(1);
        end
        ovf_clr   = 1'b0;
        evt_ready = 1'b1;
        cyc(40);
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
